adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one multi-cycle `adder` (start/done handshake, WIDTH-bit operands, WIDTH+1-bit result) between two requesters, e.g. the Montgomery loop and the final-subtraction step. Round-robin arbitration picks one request, the block captures its operands and launches the adder. It holds the operands stable until `done`, then returns the registered result to the winner. A watchdog aborts a transaction if the adder never signals `done`.

## Interface
- `WIDTH`, 513, operand width; result is WIDTH+1 bits
- `TIMEOUT`, 1024, max cycles in WAIT before abort (≥2)
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 2: request per requester (index 0/1)
- `req_subtract` in 2: 1 = a−b, 0 = a+b
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in WIDTH each: operands
- `req_ready` out 2: one-cycle accept pulse to granted requester
- `rsp_valid` out 2: one-cycle response pulse to owner
- `rsp_result` out WIDTH+1: result, valid while any `rsp_valid` is high
- `rsp_error` out 1: qualifies `rsp_valid`, 1 = timeout abort (result forced 0)
- `add_start` out 1, `add_subtract` out 1, `add_in_a`/`add_in_b` out WIDTH: adder drive
- `add_result` in WIDTH+1, `add_done` in 1: adder return; result valid only in the `done` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid`, grant per round-robin. `req_ready[g]` is combinational in this cycle. Operands, subtract and owner are captured at the edge. Next state is ISSUE.
- Round-robin: a pointer holds the last winner and resets to 1, so requester 0 wins first. When both request, the requester that is not the last winner gets the grant. When only one requests, it gets the grant regardless of the pointer. The pointer updates only on a grant.
- ISSUE: `add_start`=1 for exactly this cycle. Next state is WAIT, with the timeout counter cleared.
- WAIT: `add_start`=0. On `add_done`, register `add_result`, clear the error flag and go to RESP. If the counter reaches TIMEOUT−1 without `done`, set the error flag, zero the result register and go to RESP.
- RESP: `rsp_valid[owner]`=1 for one cycle. `rsp_result` and `rsp_error` come from registers. Next state is IDLE.
- `add_in_a`, `add_in_b` and `add_subtract` come from capture registers. They stay stable from ISSUE through RESP and change only on the next grant.
- `add_done` outside WAIT is ignored. This includes a late `done` after a timeout and a `done` after reset.
- A requester must hold `req_valid` and its operands until it sees `req_ready`. Dropping `req_valid` before grant is legal and leaves no state behind.
- No width conversion: operands pass through unchanged and the result is the adder's WIDTH+1 bits. The block performs no arithmetic itself.

## Timing
- Reset: state IDLE, pointer=1, all outputs 0 (`req_ready`, `rsp_valid`, `rsp_error`, `add_start`, `add_subtract`, `add_in_a`, `add_in_b`, `rsp_result`), counter 0.
- Grant in cycle t. `add_start` in t+1. Adder `done` in t+1+L (L≥1). `rsp_valid` in t+2+L. Earliest next grant is t+3+L.
- Timeout path: `rsp_valid` with `rsp_error`=1 occurs exactly TIMEOUT+2 cycles after grant.
- `done` and timeout in the same WAIT cycle: `done` wins and `rsp_error`=0.
- Reset mid-transaction: the transaction is dropped and no `rsp_valid` is issued. The adder sees `add_start`=0 from the next cycle.
- A new request arriving during ISSUE/WAIT/RESP waits, with no `req_ready`, until IDLE.

## Structure
- Package `adder_arb_pkg`: state enum (IDLE, ISSUE, WAIT, RESP), default WIDTH and TIMEOUT constants.
- Sub-module `rr_arbiter2`: 2-way round-robin. It takes `req[1:0]`, `last`, and an `update` strobe, and outputs a one-hot `grant`. The FSM, capture registers and watchdog live in `adder_arbiter`.

## Test plan
- Single add: req0, a=5, b=3, sub=0, adder model L=4. Expect `req_ready[0]` at t, `add_start` at t+1, `rsp_valid[0]` at t+6, result=8, error=0.
- Subtract wrap: req1, a=0, b=1, sub=1. Expect `rsp_valid[1]` and result = the adder model's 514-bit two's-complement value (all ones). `add_in_a`/`add_in_b` stay stable during WAIT.
- Contention: both valid continuously from reset, with distinct operands. Grants go 0,1,0,1, and each response pulses only on the matching `rsp_valid` bit with that requester's result.
- Timeout: TIMEOUT=8, adder model never asserts `done`. Expect `rsp_valid` with `rsp_error`=1 and result 0 at grant+10. A `done` injected 3 cycles later is ignored, and the next request completes normally.
- Done/timeout collision: `done` in the same cycle the counter hits TIMEOUT−1. Expect `rsp_error`=0 with the adder result.
- Reset mid-WAIT: assert `reset` for 1 cycle two cycles after `add_start`. Expect all outputs 0, no `rsp_valid`, the model's later `done` ignored, and the next req0 granted first.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the two-requester adder arbiter.
package adder_arb_pkg;

  localparam int WIDTH_DEFAULT   = 513;
  localparam int TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic; the pointer register lives in the caller.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       update,
  output logic [1:0] grant,
  output logic       last_next
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Under contention the requester that did not win last time goes next.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_next = last;
    if (update && (grant != 2'b00)) begin
      last_next = grant[1];
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one multi-cycle start/done adder between two requesters, with
// round-robin arbitration and a watchdog that aborts a hung transaction.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_subtract,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH:0]   rsp_result,
  output logic             rsp_error,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic             last_reg;
  logic             last_next;
  logic             owner_reg;
  logic             sub_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   result_reg;
  logic             error_reg;
  logic [CW-1:0]    cnt_reg;
  logic [1:0]       grant;
  logic             in_idle;

  assign in_idle = (state_reg == IDLE);

  rr_arbiter2 u_rr (
    .req       (req_valid),
    .last      (last_reg),
    .update    (in_idle),
    .grant     (grant),
    .last_next (last_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (add_done || (cnt_reg == CNT_LAST)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      last_reg   <= 1'b1;
      owner_reg  <= 1'b0;
      sub_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      case (state_reg)
        IDLE: begin
          if (|grant) begin
            owner_reg <= grant[1];
            sub_reg   <= grant[1] ? req_subtract[1] : req_subtract[0];
            a_reg     <= grant[1] ? req_a1 : req_a0;
            b_reg     <= grant[1] ? req_b1 : req_b0;
          end
        end
        ISSUE: cnt_reg <= '0;
        WAIT: begin
          // A done arriving on the last watchdog cycle still counts as success.
          if (add_done) begin
            result_reg <= add_result;
            error_reg  <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            result_reg <= '0;
            error_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (in_idle && !reset) ? grant : 2'b00;
  assign rsp_valid    = (state_reg == RESP) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result   = result_reg;
  assign rsp_error    = error_reg;
  assign add_start    = (state_reg == ISSUE);
  assign add_subtract = sub_reg;
  assign add_in_a     = a_reg;
  assign add_in_b     = b_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter with a behavioural variable-latency adder.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int W  = 513;
  localparam int TO = 8;
  localparam logic [W:0] JUNK = {2'b10, {128{4'h5}}};

  typedef struct {
    logic [1:0] oh;
    logic [W:0] res;
    logic       err;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_subtract = 2'b00;
  logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]   req_ready, rsp_valid;
  logic [W:0]   rsp_result;
  logic         rsp_error, add_start, add_subtract;
  logic [W-1:0] add_in_a, add_in_b;
  logic [W:0]   add_result = '0;
  logic         add_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t sb_q[$];
  exp_t mon_e;
  int   grant_log[$];
  int   grant_cyc = 0;
  int   exp_lat = 0;
  int   model_lat = 4;
  int   cd = 0;
  bit   inject_done = 1'b0;
  logic [W-1:0] a_m = '0, b_m = '0;
  logic         sub_m = 1'b0;
  logic [W:0]   last_res = '0;
  logic         last_err = 1'b0;
  logic [1:0]   last_oh = 2'b00;
  logic [W:0]   all_ones;

  adder_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_subtract (req_subtract),
    .req_a0       (req_a0),
    .req_b0       (req_b0),
    .req_a1       (req_a1),
    .req_b1       (req_b1),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_error    (rsp_error),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_in_a     (add_in_a),
    .add_in_b     (add_in_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Adder model: done (with a+b or a-b over W+1 bits) model_lat cycles after start; 0 = never.
  always @(posedge clk) begin
    #1;
    add_done   = 1'b0;
    add_result = JUNK;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        add_done   = 1'b1;
        add_result = sub_m ? ({1'b0, a_m} - {1'b0, b_m}) : ({1'b0, a_m} + {1'b0, b_m});
      end
    end
    if (inject_done) begin
      add_done    = 1'b1;
      inject_done = 1'b0;
    end
    if (add_start && model_lat > 0) begin
      cd    = model_lat;
      a_m   = add_in_a;
      b_m   = add_in_b;
      sub_m = add_subtract;
    end
  end

  // Monitor: push expectation on grant, pop and compare on response.
  always @(negedge clk) begin
    if (!reset) begin
      if (req_ready != 2'b00) begin
        logic g;
        logic [W-1:0] a, b;
        logic s;
        g = req_ready[1];
        check("ready_onehot", (req_ready == 2'b01) || (req_ready == 2'b10), 1);
        grant_log.push_back(int'(g));
        grant_cyc = cyc;
        a = g ? req_a1 : req_a0;
        b = g ? req_b1 : req_b0;
        s = req_subtract[g];
        mon_e.oh = g ? 2'b10 : 2'b01;
        if (model_lat == 0 || model_lat > TO) begin
          mon_e.res = '0;
          mon_e.err = 1'b1;
          exp_lat   = TO + 2;
        end else begin
          mon_e.res = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
          mon_e.err = 1'b0;
          exp_lat   = model_lat + 2;
        end
        sb_q.push_back(mon_e);
      end
      if (add_start) check("start_lat", cyc - grant_cyc, 1);
      if (rsp_valid != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_owner", rsp_valid, mon_e.oh);
          check("rsp_result", rsp_result, mon_e.res);
          check("rsp_error", rsp_error, mon_e.err);
          check("rsp_lat", cyc - grant_cyc, exp_lat);
          last_res = rsp_result;
          last_err = rsp_error;
          last_oh  = rsp_valid;
        end
        $display("rsp owner=%b err=%0d result=%h", rsp_valid, rsp_error, rsp_result);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb_q.delete();
    grant_log.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_add_start"}, add_start, 0);
    check({tag, "_add_sub"}, add_subtract, 0);
    check({tag, "_add_in_a"}, add_in_a, 0);
    check({tag, "_add_in_b"}, add_in_b, 0);
  endtask

  task automatic request(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bit got = 1'b0;
    if (idx == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_subtract[idx] = sub;
    req_valid[idx] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready[idx]) begin got = 1'b1; break; end
    end
    if (!got) check("grant_wait", 0, 1);
    tick();
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check("drain", sb_q.size(), 0);
    tick();
  endtask

  initial begin
    all_ones = '1;

    // Reset values
    do_reset();
    @(negedge clk);
    check_outputs_zero("reset");
    tick();

    // Single add, latency 4
    model_lat = 4;
    request(0, 513'd5, 513'd3, 1'b0);
    drain();
    check("add_result_8", last_res, 8);
    check("add_owner0", last_oh, 2'b01);

    // Subtract wrap on requester 1; operands hold during WAIT
    request(1, 513'd0, 513'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("hold_a", add_in_a, 0);
      check("hold_b", add_in_b, 1);
      check("hold_sub", add_subtract, 1);
      tick();
    end
    drain();
    check("wrap_all_ones", last_res, all_ones);
    check("wrap_owner1", last_oh, 2'b10);

    // Contention from reset: grants alternate starting with 0
    model_lat = 2;
    req_a0 = 513'd1000; req_b0 = 513'd24; req_a1 = 513'd77; req_b1 = 513'd7;
    req_subtract = 2'b10;
    req_valid = 2'b11;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (grant_log.size() >= 4) break;
      tick();
    end
    req_valid = 2'b00;
    drain();
    check("rr_count", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), grant_log[i], i % 2);
    end

    // Watchdog timeout, then a stray done is ignored
    model_lat = 0;
    request(0, 513'd7, 513'd9, 1'b0);
    drain();
    check("to_error", last_err, 1);
    check("to_result0", last_res, 0);
    tick();
    inject_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("late_done_ignored", rsp_valid, 0);
    end
    model_lat = 3;
    request(1, 513'd100, 513'd23, 1'b1);
    drain();
    check("after_to_result", last_res, 77);
    check("after_to_error", last_err, 0);

    // done on the last watchdog cycle wins
    model_lat = TO;
    request(0, 513'd11, 513'd22, 1'b0);
    drain();
    check("collide_error", last_err, 0);
    check("collide_result", last_res, 33);

    // Reset two cycles after add_start drops the transaction
    model_lat = 4;
    request(0, 513'd1, 513'd2, 1'b0);
    check("mid_start_seen", add_start, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    check_outputs_zero("midreset");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midreset_no_rsp", rsp_valid, 0);
      check("midreset_no_start", add_start, 0);
    end
    model_lat = 2;
    req_a0 = 513'd40; req_b0 = 513'd2; req_a1 = 513'd50; req_b1 = 513'd5;
    req_subtract = 2'b00;
    req_valid = 2'b11;
    begin
      bit got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin got = 1'b1; break; end
      end
      check("post_reset_grant_seen", got, 1);
      check("post_reset_first", req_ready, 2'b01);
    end
    tick();
    req_valid[0] = 1'b0;
    request(1, 513'd50, 513'd5, 1'b0);
    drain();
    check("post_reset_last", last_res, 55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
